// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Releases a synchronous, active-low reset into the PLL output clock domain
// only after the PLL lock flag has been stable for LOCK_STABLE_CYCLES and a
// further RESET_HOLD_CYCLES have elapsed. Any loss of lock re-asserts reset
// and restarts the whole qualification sequence.
//
// Optional feature macro: LOCK_LOSS_COUNT_EN
//   defined   -> 8-bit saturating lock-loss counter with synchronous clear
//   undefined -> lock_loss_count is tied to zero and clear_count is ignored
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked_async,
    input  logic       clear_count,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] syncChain_q;
    logic                   lockS;
    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sysRstN_q;
    logic                   ready_q;
    logic                   lossEvent;

    // Bring the asynchronous lock flag into the clk domain; only the last stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncChain_q <= '0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], locked_async};
        end
    end

    assign lockS = syncChain_q[SYNC_STAGES-1];

    // Qualification FSM; any lock drop falls through to the WAIT_LOCK defaults, outputs decode the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sysRstN_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            sysRstN_q <= 1'b0;
            ready_q   <= 1'b0;
            case (state_q)
                WAIT_LOCK: begin
                    if (lockS) begin
                        state_q <= STABILIZE;
                    end
                end
                STABILIZE: begin
                    if (lockS) begin
                        if (cnt_q == STABLE_LAST) begin
                            state_q <= HOLD;
                        end else begin
                            state_q <= STABILIZE;
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (lockS) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_q   <= RUN;
                            sysRstN_q <= 1'b1;
                            ready_q   <= 1'b1;
                        end else begin
                            state_q <= HOLD;
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                end
                RUN: begin
                    if (lockS) begin
                        state_q   <= RUN;
                        sysRstN_q <= 1'b1;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign sys_rst_n = sysRstN_q;
    assign ready     = ready_q;

    assign lossEvent = (state_q == RUN) && !lockS;

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] lossCount_q;
    logic [7:0] lossCount_d;

    // Clear discards history but still records a loss in the same cycle; increments saturate at 255.
    always_comb begin
        lossCount_d = lossCount_q;
        if (clear_count) begin
            lossCount_d = lossEvent ? 8'd1 : 8'd0;
        end else if (lossEvent && (lossCount_q != 8'hFF)) begin
            lossCount_d = lossCount_q + 8'd1;
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lossCount_q <= 8'd0;
        end else begin
            lossCount_q <= lossCount_d;
        end
    end

    assign lock_loss_count = lossCount_q;
`else
    logic unusedCountInputs;

    assign unusedCountInputs = clear_count ^ lossEvent;
    assign lock_loss_count   = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer (S=2, L=8, H=4).
// The reference model treats the synchronizer as a pure S-cycle delay and
// the FSM as "ready once the synchronized lock has been high for the last
// 1+L+H edges"; lock losses are falling edges of that expected ready.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int S        = 2;
    localparam int L        = 8;
    localparam int H        = 4;
    localparam int RUN_EDGE = S + 1 + L + H;
    localparam int RUN_NEED = 1 + L + H;

`ifdef LOCK_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked_async;
    logic       clear_count;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] lock_loss_count;

    int testsRun  = 0;
    int failCount = 0;

    int runLen;
    bit expRun;
    int expCount;
    bit syncM[$];

    pll_reset_sequencer #(
        .SYNC_STAGES       (S),
        .LOCK_STABLE_CYCLES(L),
        .RESET_HOLD_CYCLES (H)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .locked_async   (locked_async),
        .clear_count    (clear_count),
        .sys_rst_n      (sys_rst_n),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    function automatic void modelReset();
        runLen   = 0;
        expRun   = 1'b0;
        expCount = 0;
        syncM.delete();
        for (int i = 0; i < S; i++) syncM.push_back(1'b0);
    endfunction

    function automatic void modelStep();
        bit newRun;
        bit loss;
        bit lockS;
        newRun = (runLen >= RUN_NEED);
        loss   = expRun && !newRun;
        if (CNT_EN) begin
            if (clear_count) expCount = loss ? 1 : 0;
            else if (loss && expCount < 255) expCount = expCount + 1;
        end
        expRun = newRun;
        syncM.push_front(locked_async);
        void'(syncM.pop_back());
        lockS  = syncM[S-1];
        runLen = lockS ? runLen + 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_count  = 1'b0;
        locked_async = 1'b1;
        rst_n        = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        testsRun++;
        if (sys_rst_n !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n);
        end
        testsRun++;
        if (ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready);
        end
        testsRun++;
        if (lock_loss_count !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL reset_count: got %0d expected 0", lock_loss_count);
        end
    endtask

    task automatic test_startup();
        locked_async = 1'b1;
        applyReset();
        for (int e = 1; e <= RUN_EDGE + 4; e++) begin
            tick();
            testsRun++;
            if (sys_rst_n !== (e >= RUN_EDGE)) begin
                failCount++;
                $display("[TB] FAIL startup_sys_rst_n edge %0d: got %b expected %b", e, sys_rst_n, (e >= RUN_EDGE));
            end
            testsRun++;
            if (ready !== expRun) begin
                failCount++;
                $display("[TB] FAIL startup_ready edge %0d: got %b expected %b", e, ready, expRun);
            end
        end
        testsRun++;
        if (lock_loss_count !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL startup_count: got %0d expected 0", lock_loss_count);
        end
    endtask

    task automatic test_stabilize_abort();
        locked_async = 1'b0;
        applyReset();
        locked_async = 1'b1;
        repeat (6) tick();
        locked_async = 1'b0;
        repeat (3) tick();
        testsRun++;
        if (sys_rst_n !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL abort_early_release: got %b expected 0", sys_rst_n);
        end
        locked_async = 1'b1;
        for (int e = 1; e <= RUN_EDGE + 2; e++) begin
            tick();
            testsRun++;
            if (sys_rst_n !== (e >= RUN_EDGE)) begin
                failCount++;
                $display("[TB] FAIL abort_restart edge %0d: got %b expected %b", e, sys_rst_n, (e >= RUN_EDGE));
            end
        end
    endtask

    task automatic test_lock_loss();
        locked_async = 1'b0;
        for (int e = 0; e <= 2; e++) begin
            tick();
            testsRun++;
            if (ready !== (e < 2)) begin
                failCount++;
                $display("[TB] FAIL loss_ready edge k+%0d: got %b expected %b", e, ready, (e < 2));
            end
            testsRun++;
            if (sys_rst_n !== (e < 2)) begin
                failCount++;
                $display("[TB] FAIL loss_sys_rst_n edge k+%0d: got %b expected %b", e, sys_rst_n, (e < 2));
            end
        end
        testsRun++;
        if (lock_loss_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
            failCount++;
            $display("[TB] FAIL loss_count: got %0d expected %0d", lock_loss_count, (CNT_EN ? 1 : 0));
        end
        locked_async = 1'b1;
        for (int e = 1; e <= RUN_EDGE; e++) begin
            tick();
            testsRun++;
            if (ready !== (e >= RUN_EDGE)) begin
                failCount++;
                $display("[TB] FAIL loss_relock edge %0d: got %b expected %b", e, ready, (e >= RUN_EDGE));
            end
        end
    endtask

    task automatic test_hold_drop();
        locked_async = 1'b0;
        repeat (3) tick();
        locked_async = 1'b1;
        repeat (12) tick();
        locked_async = 1'b0;
        for (int e = 0; e < 20; e++) begin
            tick();
            testsRun++;
            if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL hold_drop_pulse cycle %0d: got sys_rst_n=%b ready=%b expected 0", e, sys_rst_n, ready);
            end
        end
        testsRun++;
        if (lock_loss_count !== (CNT_EN ? 8'd2 : 8'd0)) begin
            failCount++;
            $display("[TB] FAIL hold_drop_count: got %0d expected %0d", lock_loss_count, (CNT_EN ? 2 : 0));
        end
    endtask

    task automatic test_reset_in_hold();
        locked_async = 1'b1;
        repeat (12) tick();
        #3;
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0 || lock_loss_count !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL async_reset: got sys_rst_n=%b ready=%b count=%0d expected all 0", sys_rst_n, ready, lock_loss_count);
        end
        applyReset();
        for (int e = 1; e <= RUN_EDGE; e++) begin
            tick();
            testsRun++;
            if (ready !== (e >= RUN_EDGE)) begin
                failCount++;
                $display("[TB] FAIL async_reset_restart edge %0d: got %b expected %b", e, ready, (e >= RUN_EDGE));
            end
        end
    endtask

    task automatic test_saturation();
        locked_async = 1'b1;
        applyReset();
        for (int i = 0; i < 300; i++) begin
            locked_async = 1'b1;
            repeat (RUN_EDGE) tick();
            testsRun++;
            if (ready !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL sat_run loop %0d: got %b expected 1", i, ready);
            end
            locked_async = 1'b0;
            repeat (3) tick();
            testsRun++;
            if (ready !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL sat_drop loop %0d: got %b expected 0", i, ready);
            end
        end
        testsRun++;
        if (lock_loss_count !== (CNT_EN ? 8'd255 : 8'd0)) begin
            failCount++;
            $display("[TB] FAIL sat_count: got %0d expected %0d", lock_loss_count, (CNT_EN ? 255 : 0));
        end
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        testsRun++;
        if (lock_loss_count !== 8'd0) begin
            failCount++;
            $display("[TB] FAIL clear_count: got %0d expected 0", lock_loss_count);
        end
        locked_async = 1'b1;
        repeat (RUN_EDGE) tick();
        locked_async = 1'b0;
        repeat (2) tick();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        testsRun++;
        if (lock_loss_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
            failCount++;
            $display("[TB] FAIL clear_with_loss: got %0d expected %0d", lock_loss_count, (CNT_EN ? 1 : 0));
        end
    endtask

    task automatic test_random();
        locked_async = 1'b1;
        clear_count  = 1'b0;
        applyReset();
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            locked_async = ($urandom_range(0, 2) != 0);
            len = locked_async ? $urandom_range(1, 40) : $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                clear_count = ($urandom_range(0, 19) == 0);
                tick();
                testsRun++;
                if (ready !== expRun || sys_rst_n !== expRun) begin
                    failCount++;
                    $display("[TB] FAIL random_ready seg %0d: got ready=%b sys_rst_n=%b expected %b", seg, ready, sys_rst_n, expRun);
                end
                testsRun++;
                if (lock_loss_count !== 8'(expCount)) begin
                    failCount++;
                    $display("[TB] FAIL random_count seg %0d: got %0d expected %0d", seg, lock_loss_count, expCount);
                end
            end
        end
        clear_count = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stabilize_abort();
        test_lock_loss();
        test_hold_drop();
        test_reset_in_hold();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
